// File: rtl/key_cursor_ctrl.sv
// key_cursor_ctrl
// Front-end control for the text cursor. Synchronises and debounces the raw
// character and newline keys, turns each accepted character into a single
// write strobe followed by a column step, and keeps the row index. The column
// itself lives in an external 6-bit counter driven through COL_EN / COL_CLR.
module key_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,  // stable cycles to accept a press or a release (>= 2)
    parameter int COL_MAX         = 63,  // last column index (<= 63)
    parameter int ROW_BITS        = 5,   // width of ROW_Q
    parameter int ROW_MAX         = 29   // last row index before wrapping to 0
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                KEY_CHAR,
    input  logic                KEY_NL,
    input  logic [5:0]          COL_Q,
    output logic                COL_EN,
    output logic                COL_CLR,
    output logic [ROW_BITS-1:0] ROW_Q,
    output logic                WR_STROBE,
    output logic                BUSY
);

    // Debounce counters must be able to hold DEBOUNCE_CYCLES itself, because a
    // counter reaches that value on the edge where its key is accepted.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t                CNT_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]          COL_LAST = 6'(COL_MAX);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROW_MAX);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        ADVANCE,
        NEWLINE,
        WAIT_REL
    } state_t;

    state_t state;

    logic char_meta, char_s;
    logic nl_meta,   nl_s;

    cnt_t char_cnt;
    cnt_t nl_cnt;
    cnt_t rel_cnt;

    logic col_clr_reg;

    logic                char_hit;
    logic                nl_hit;
    logic                both_low;
    logic                rel_done;
    logic [ROW_BITS-1:0] next_row;

    // A key qualifies on the edge that would complete its run of
    // DEBOUNCE_CYCLES consecutive high samples (current sample included).
    assign char_hit = char_s && (char_cnt == CNT_LAST);
    assign nl_hit   = nl_s   && (nl_cnt   == CNT_LAST);
    assign both_low = !char_s && !nl_s;
    assign rel_done = both_low && (rel_cnt == CNT_LAST);

    assign next_row = (ROW_Q == ROW_LAST) ? '0 : ROW_Q + 1'b1;

    // The external counter is also cleared for as long as reset is held.
    assign COL_CLR = CLR | col_clr_reg;

    // Two-flop synchronisers for the asynchronous key levels.
    always_ff @(posedge CLK) begin
        // NOTE: every clocked block uses non-blocking assignments so all
        // registers update together from the values present before the edge.
        if (CLR) begin
            char_meta <= 1'b0;
            char_s    <= 1'b0;
            nl_meta   <= 1'b0;
            nl_s      <= 1'b0;
        end else begin
            char_meta <= KEY_CHAR;
            char_s    <= char_meta;
            nl_meta   <= KEY_NL;
            nl_s      <= nl_meta;
        end
    end

    // Press run-length counters: only count while idle, any low sample restarts.
    always_ff @(posedge CLK) begin
        if (CLR || state != IDLE) begin
            char_cnt <= '0;
            nl_cnt   <= '0;
        end else begin
            char_cnt <= char_s ? char_cnt + cnt_t'(1) : '0;
            nl_cnt   <= nl_s   ? nl_cnt   + cnt_t'(1) : '0;
        end
    end

    // Release run-length counter: both keys low, only while waiting for release.
    always_ff @(posedge CLK) begin
        if (CLR || state != WAIT_REL) begin
            rel_cnt <= '0;
        end else begin
            rel_cnt <= both_low ? rel_cnt + cnt_t'(1) : '0;
        end
    end

    // Main FSM with registered pulse outputs and row tracking.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state       <= IDLE;
            WR_STROBE   <= 1'b0;
            COL_EN      <= 1'b0;
            col_clr_reg <= 1'b0;
            ROW_Q       <= '0;
            BUSY        <= 1'b0;
        end else begin
            // NOTE: pulses default low here so each one lasts exactly the
            // single cycle of the state that raises it.
            WR_STROBE   <= 1'b0;
            COL_EN      <= 1'b0;
            col_clr_reg <= 1'b0;

            case (state)
                IDLE: begin
                    // Newline takes priority when both keys qualify together.
                    if (nl_hit) begin
                        state       <= NEWLINE;
                        col_clr_reg <= 1'b1;
                        ROW_Q       <= next_row;
                        BUSY        <= 1'b1;
                    end else if (char_hit) begin
                        state     <= WRITE;
                        WR_STROBE <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end

                WRITE: begin
                    // COL_Q is captured on the edge that opens ADVANCE, so the
                    // step pulse occupies the ADVANCE cycle right after the write.
                    state <= ADVANCE;
                    if (COL_Q < COL_LAST) begin
                        COL_EN <= 1'b1;
                    end else begin
                        col_clr_reg <= 1'b1;
                        ROW_Q       <= next_row;
                    end
                end

                ADVANCE: begin
                    state <= WAIT_REL;
                end

                NEWLINE: begin
                    state <= WAIT_REL;
                end

                WAIT_REL: begin
                    // No auto-repeat: both keys must be released and stay released.
                    if (rel_done) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
